// File: rtl/am_query_scheduler_pkg.sv
// Shared widths, defaults and state encoding for the AM query scheduler.
package am_query_scheduler_pkg;

    localparam int HV_DIMENSION       = 64;
    localparam int LABEL_WIDTH        = 4;
    localparam int DISTANCE_WIDTH     = 8;
    localparam int AMS_NUM_REQ        = 3;
    localparam int AMS_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_ARBITRATE     = 2'd0,
        ST_SEND_QUERY    = 2'd1,
        ST_WAIT_RESULT   = 2'd2,
        ST_OUTPUT_STABLE = 2'd3
    } ams_state_e;

    // Bits needed to index n items, never less than one.
    function automatic int ceil_log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/am_query_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first valid request at or above pointer.
module am_query_scheduler_rr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] pointer,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                any
);

    logic [ID_WIDTH:0]   sum;
    logic [ID_WIDTH-1:0] idx;

    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        sum          = '0;
        idx          = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, pointer} + (ID_WIDTH+1)'(off);
            if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (ID_WIDTH+1)'(NUM_REQ);
            end
            idx = sum[ID_WIDTH-1:0];
            if (!any && req[idx]) begin
                any               = 1'b1;
                grant_id          = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/am_query_scheduler.sv
// Shares one associative memory between several query producers,
// round-robin, returning tagged results and flagging lost AM responses.
module am_query_scheduler
    import am_query_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = AMS_NUM_REQ,
    parameter int ID_WIDTH       = ceil_log2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = AMS_TIMEOUT_CYCLES
) (
    input  logic                              Clk_CI,
    input  logic                              Reset_RI,
    input  logic [NUM_REQ-1:0]                ReqValid_SI,
    output logic [NUM_REQ-1:0]                ReqReady_SO,
    input  logic [NUM_REQ*HV_DIMENSION-1:0]   ReqHypervector_DI,
    output logic                              AmValid_SO,
    input  logic                              AmReady_SI,
    output logic [HV_DIMENSION-1:0]           AmHypervector_DO,
    input  logic                              AmValid_SI,
    output logic                              AmReady_SO,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_A_DI,
    input  logic [LABEL_WIDTH-1:0]            AmLabel_V_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_A_DI,
    input  logic [DISTANCE_WIDTH-1:0]         AmDistance_V_DI,
    output logic                              ValidOut_SO,
    input  logic                              ReadyIn_SI,
    output logic [ID_WIDTH-1:0]               ReqIdOut_DO,
    output logic [LABEL_WIDTH-1:0]            LabelOut_A_DO,
    output logic [LABEL_WIDTH-1:0]            LabelOut_V_DO,
    output logic [DISTANCE_WIDTH-1:0]         DistanceOut_A_DO,
    output logic [DISTANCE_WIDTH-1:0]         DistanceOut_V_DO,
    output logic                              TimeoutErr_SO
);

    localparam int WD_W = ceil_log2(TIMEOUT_CYCLES);

    ams_state_e state_q, state_d;

    logic [NUM_REQ-1:0]      gnt_oh;
    logic [ID_WIDTH-1:0]     gnt_id;
    logic                    gnt_any;
    logic [ID_WIDTH-1:0]     ptr_q;
    logic [ID_WIDTH-1:0]     tag_q;
    logic [HV_DIMENSION-1:0] query_q;
    logic [WD_W-1:0]         wd_q;
    logic                    wd_expired;
    logic                    err_q;
    logic [LABEL_WIDTH-1:0]  lab_a_q, lab_v_q;
    logic [DISTANCE_WIDTH-1:0] dist_a_q, dist_v_q;
    logic [HV_DIMENSION-1:0] req_hv [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign req_hv[g] = ReqHypervector_DI[g*HV_DIMENSION +: HV_DIMENSION];
    end

    am_query_scheduler_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req          (ReqValid_SI),
        .pointer      (ptr_q),
        .grant_onehot (gnt_oh),
        .grant_id     (gnt_id),
        .any          (gnt_any)
    );

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) state_q <= ST_ARBITRATE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARBITRATE:     if (gnt_any) state_d = ST_SEND_QUERY;
            ST_SEND_QUERY:    if (AmReady_SI) state_d = ST_WAIT_RESULT;
            ST_WAIT_RESULT: begin
                if (AmValid_SI)      state_d = ST_OUTPUT_STABLE;
                else if (wd_expired) state_d = ST_ARBITRATE;
            end
            ST_OUTPUT_STABLE: if (ReadyIn_SI) state_d = ST_ARBITRATE;
        endcase
    end

    // Handshakes are masked during reset so nothing is accepted or issued.
    always_comb begin
        ReqReady_SO = '0;
        AmValid_SO  = 1'b0;
        AmReady_SO  = 1'b0;
        ValidOut_SO = 1'b0;
        if (!Reset_RI) begin
            case (state_q)
                ST_ARBITRATE:     ReqReady_SO = gnt_oh;
                ST_SEND_QUERY:    AmValid_SO  = 1'b1;
                ST_WAIT_RESULT:   AmReady_SO  = 1'b1;
                ST_OUTPUT_STABLE: ValidOut_SO = 1'b1;
            endcase
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            ptr_q    <= '0;
            tag_q    <= '0;
            query_q  <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            lab_a_q  <= '0;
            lab_v_q  <= '0;
            dist_a_q <= '0;
            dist_v_q <= '0;
        end else begin
            case (state_q)
                ST_ARBITRATE: begin
                    if (gnt_any) begin
                        query_q <= req_hv[gnt_id];
                        tag_q   <= gnt_id;
                        ptr_q   <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ?
                                   '0 : gnt_id + ID_WIDTH'(1);
                    end
                end
                ST_SEND_QUERY: if (AmReady_SI) wd_q <= '0;
                ST_WAIT_RESULT: begin
                    if (AmValid_SI) begin
                        lab_a_q  <= AmLabel_A_DI;
                        lab_v_q  <= AmLabel_V_DI;
                        dist_a_q <= AmDistance_A_DI;
                        dist_v_q <= AmDistance_V_DI;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                        if (wd_expired) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign AmHypervector_DO = query_q;
    assign ReqIdOut_DO      = tag_q;
    assign LabelOut_A_DO    = lab_a_q;
    assign LabelOut_V_DO    = lab_v_q;
    assign DistanceOut_A_DO = dist_a_q;
    assign DistanceOut_V_DO = dist_v_q;
    assign TimeoutErr_SO    = err_q;

endmodule

// File: tb/tb_am_query_scheduler.sv
// Scoreboard bench for am_query_scheduler with a behavioural AM responder.
module tb_am_query_scheduler;
    import am_query_scheduler_pkg::*;

    localparam int NR  = 3;
    localparam int IDW = 2;
    localparam int TO  = 8;
    localparam int HV  = HV_DIMENSION;
    localparam int LW  = LABEL_WIDTH;
    localparam int DW  = DISTANCE_WIDTH;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [LW-1:0]  la;
        logic [LW-1:0]  lv;
        logic [DW-1:0]  da;
        logic [DW-1:0]  dv;
    } res_t;

    logic              Clk_CI;
    logic              Reset_RI;
    logic [NR-1:0]     ReqValid_SI;
    logic [NR-1:0]     ReqReady_SO;
    logic [NR*HV-1:0]  ReqHypervector_DI;
    logic              AmValid_SO;
    logic              AmReady_SI;
    logic [HV-1:0]     AmHypervector_DO;
    logic              AmValid_SI;
    logic              AmReady_SO;
    logic [LW-1:0]     AmLabel_A_DI, AmLabel_V_DI;
    logic [DW-1:0]     AmDistance_A_DI, AmDistance_V_DI;
    logic              ValidOut_SO;
    logic              ReadyIn_SI;
    logic [IDW-1:0]    ReqIdOut_DO;
    logic [LW-1:0]     LabelOut_A_DO, LabelOut_V_DO;
    logic [DW-1:0]     DistanceOut_A_DO, DistanceOut_V_DO;
    logic              TimeoutErr_SO;

    am_query_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk_CI            (Clk_CI),
        .Reset_RI          (Reset_RI),
        .ReqValid_SI       (ReqValid_SI),
        .ReqReady_SO       (ReqReady_SO),
        .ReqHypervector_DI (ReqHypervector_DI),
        .AmValid_SO        (AmValid_SO),
        .AmReady_SI        (AmReady_SI),
        .AmHypervector_DO  (AmHypervector_DO),
        .AmValid_SI        (AmValid_SI),
        .AmReady_SO        (AmReady_SO),
        .AmLabel_A_DI      (AmLabel_A_DI),
        .AmLabel_V_DI      (AmLabel_V_DI),
        .AmDistance_A_DI   (AmDistance_A_DI),
        .AmDistance_V_DI   (AmDistance_V_DI),
        .ValidOut_SO       (ValidOut_SO),
        .ReadyIn_SI        (ReadyIn_SI),
        .ReqIdOut_DO       (ReqIdOut_DO),
        .LabelOut_A_DO     (LabelOut_A_DO),
        .LabelOut_V_DO     (LabelOut_V_DO),
        .DistanceOut_A_DO  (DistanceOut_A_DO),
        .DistanceOut_V_DO  (DistanceOut_V_DO),
        .TimeoutErr_SO     (TimeoutErr_SO)
    );

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    int   total = 0;
    int   bad   = 0;
    res_t exp_q[$];
    int   grant_log[$];
    bit   am_respond = 1'b1;
    int   am_latency = 1;
    bit   am_clear   = 1'b0;

    // The AM answers with fields taken from the low bytes of the query.
    function automatic res_t am_model(input logic [HV-1:0] hv,
                                      input int id);
        res_t r;
        r.id = IDW'(id);
        r.la = hv[3:0];
        r.lv = hv[7:4];
        r.da = hv[15:8];
        r.dv = hv[23:16];
        return r;
    endfunction

    initial begin : am_responder
        int st;
        int cnt;
        logic [HV-1:0] hv;
        st = 0;
        cnt = 0;
        hv = '0;
        AmValid_SI = 1'b0;
        AmReady_SI = 1'b1;
        AmLabel_A_DI = '0;
        AmLabel_V_DI = '0;
        AmDistance_A_DI = '0;
        AmDistance_V_DI = '0;
        forever begin
            @(negedge Clk_CI);
            #1;
            if (am_clear) begin
                st = 0;
                am_clear = 1'b0;
            end
            if (st == 0) begin
                AmValid_SI = 1'b0;
                AmReady_SI = 1'b1;
                if (AmValid_SO) begin
                    hv = AmHypervector_DO;
                    cnt = am_latency;
                    st = 1;
                end
            end else begin
                AmReady_SI = 1'b0;
                if (!AmReady_SO) begin
                    st = 0;
                end else if (cnt > 0) begin
                    cnt--;
                end else if (am_respond) begin
                    AmValid_SI = 1'b1;
                    AmLabel_A_DI = hv[3:0];
                    AmLabel_V_DI = hv[7:4];
                    AmDistance_A_DI = hv[15:8];
                    AmDistance_V_DI = hv[23:16];
                    st = 0;
                end
            end
        end
    end

    initial begin : monitor
        res_t e, got;
        forever begin
            @(negedge Clk_CI);
            #2;
            if (!Reset_RI) begin
                if (ReqReady_SO != '0) begin
                    total++;
                    if (!$onehot(ReqReady_SO) ||
                        ((ReqReady_SO & ~ReqValid_SI) != '0)) begin
                        bad++;
                        $display("FAIL req_ready_onehot: got %b valid %b",
                                 ReqReady_SO, ReqValid_SI);
                    end
                end
                for (int i = 0; i < NR; i++) begin
                    if (ReqReady_SO[i] && ReqValid_SI[i]) begin
                        exp_q.push_back(am_model(ReqHypervector_DI[i*HV +: HV], i));
                        grant_log.push_back(i);
                    end
                end
                if (ValidOut_SO && ReadyIn_SI) begin
                    total++;
                    got = {ReqIdOut_DO, LabelOut_A_DO, LabelOut_V_DO,
                           DistanceOut_A_DO, DistanceOut_V_DO};
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL result_unexpected: got %h want none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            bad++;
                            $display("FAIL result: got %h want %h", got, e);
                        end
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge Clk_CI);
        Reset_RI = 1'b1;
        ReqValid_SI = '0;
        am_clear = 1'b1;
        @(negedge Clk_CI);
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        exp_q.delete();
        grant_log.delete();
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clk_CI);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: pending %0d want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk_CI);
        #2;
        total++;
        if ({AmValid_SO, AmReady_SO, ValidOut_SO} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hs: got %b want 000",
                     {AmValid_SO, AmReady_SO, ValidOut_SO});
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        #2;
        total++;
        if (TimeoutErr_SO !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b want 0", TimeoutErr_SO);
        end
        total++;
        if ({ReqIdOut_DO, LabelOut_A_DO, LabelOut_V_DO, DistanceOut_A_DO,
             DistanceOut_V_DO} !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0",
                     {ReqIdOut_DO, LabelOut_A_DO, DistanceOut_A_DO});
        end
        total++;
        if (AmHypervector_DO !== '0) begin
            bad++;
            $display("FAIL reset_hv: got %h want 0", AmHypervector_DO);
        end
    endtask

    task automatic test_single();
        logic [HV-1:0] hv;
        bit seen;
        hv = 64'hA5A5_A5A5_A534_2501;
        @(negedge Clk_CI);
        ReadyIn_SI = 1'b1;
        ReqHypervector_DI[1*HV +: HV] = hv;
        ReqValid_SI = 3'b010;
        #2;
        total++;
        if (ReqReady_SO !== 3'b010) begin
            bad++;
            $display("FAIL single_ready: got %b want 010", ReqReady_SO);
        end
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        #2;
        total++;
        if (AmValid_SO !== 1'b1 || AmHypervector_DO !== hv) begin
            bad++;
            $display("FAIL single_am: got %b %h want 1 %h",
                     AmValid_SO, AmHypervector_DO, hv);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk_CI);
            #2;
            if (ValidOut_SO) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || ReqIdOut_DO !== 2'd1 || LabelOut_A_DO !== 4'd1 ||
            LabelOut_V_DO !== 4'd0 || DistanceOut_A_DO !== 8'd37 ||
            DistanceOut_V_DO !== 8'd52) begin
            bad++;
            $display("FAIL single_result: got v%b id%0d a%0d v%0d da%0d dv%0d want v1 id1 a1 v0 da37 dv52",
                     seen, ReqIdOut_DO, LabelOut_A_DO, LabelOut_V_DO,
                     DistanceOut_A_DO, DistanceOut_V_DO);
        end
        drain("single");
    endtask

    task automatic test_contention();
        apply_reset();
        ReadyIn_SI = 1'b1;
        am_latency = 2;
        for (int i = 0; i < NR; i++) begin
            ReqHypervector_DI[i*HV +: HV] = {$urandom, $urandom};
        end
        ReqValid_SI = 3'b111;
        for (int k = 0; k < 300; k++) begin
            @(negedge Clk_CI);
            if (grant_log.size() >= 6) break;
        end
        ReqValid_SI = '0;
        total++;
        if (grant_log.size() != 6) begin
            bad++;
            $display("FAIL contention_count: got %0d want 6", grant_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                total++;
                if (grant_log[k] != k % 3) begin
                    bad++;
                    $display("FAIL contention_order[%0d]: got %0d want %0d",
                             k, grant_log[k], k % 3);
                end
            end
        end
        drain("contention");
        am_latency = 1;
    endtask

    task automatic test_wrap();
        int want[3];
        want = '{2, 0, 2};
        apply_reset();
        ReqValid_SI = 3'b100;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk_CI);
            if (grant_log.size() >= 1) break;
        end
        ReqValid_SI = 3'b101;
        for (int k = 0; k < 100; k++) begin
            @(negedge Clk_CI);
            if (grant_log.size() >= 3) break;
        end
        ReqValid_SI = '0;
        total++;
        if (grant_log.size() != 3) begin
            bad++;
            $display("FAIL wrap_count: got %0d want 3", grant_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                total++;
                if (grant_log[k] != want[k]) begin
                    bad++;
                    $display("FAIL wrap_order[%0d]: got %0d want %0d",
                             k, grant_log[k], want[k]);
                end
            end
        end
        drain("wrap");
    endtask

    task automatic test_backpressure();
        logic [IDW+2*LW+2*DW-1:0] snap;
        bit seen;
        apply_reset();
        ReadyIn_SI = 1'b0;
        ReqHypervector_DI[0 +: HV] = 64'h0123_4567_89AB_CDEF;
        ReqHypervector_DI[HV +: HV] = 64'hFEDC_BA98_7654_3210;
        ReqValid_SI = 3'b011;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge Clk_CI);
            #2;
            if (ValidOut_SO) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp_valid: got 0 want 1");
        end
        snap = {ReqIdOut_DO, LabelOut_A_DO, LabelOut_V_DO,
                DistanceOut_A_DO, DistanceOut_V_DO};
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk_CI);
            #2;
            total++;
            if ({ValidOut_SO, ReqReady_SO, ReqIdOut_DO, LabelOut_A_DO,
                 LabelOut_V_DO, DistanceOut_A_DO, DistanceOut_V_DO} !==
                {1'b1, 3'b000, snap}) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v%b r%b %h want v1 r000 %h",
                         k, ValidOut_SO, ReqReady_SO,
                         {ReqIdOut_DO, LabelOut_A_DO, LabelOut_V_DO,
                          DistanceOut_A_DO, DistanceOut_V_DO}, snap);
            end
        end
        @(negedge Clk_CI);
        ReadyIn_SI = 1'b1;
        #2;
        total++;
        if (ReqReady_SO !== 3'b000) begin
            bad++;
            $display("FAIL bp_release_same: got %b want 000", ReqReady_SO);
        end
        @(negedge Clk_CI);
        #2;
        total++;
        if (ReqReady_SO !== 3'b010) begin
            bad++;
            $display("FAIL bp_next_grant: got %b want 010", ReqReady_SO);
        end
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        drain("bp");
    endtask

    task automatic test_watchdog();
        int cnt;
        bit seen_valid;
        bit hit;
        am_respond = 1'b0;
        ReadyIn_SI = 1'b1;
        @(negedge Clk_CI);
        ReqHypervector_DI[2*HV +: HV] = 64'h1111_2222_3333_4444;
        ReqValid_SI = 3'b100;
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        cnt = 0;
        seen_valid = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (ValidOut_SO) seen_valid = 1'b1;
            if (AmReady_SO) cnt++;
            if (TimeoutErr_SO) begin
                hit = 1'b1;
                break;
            end
            @(negedge Clk_CI);
        end
        total++;
        if (!hit || cnt != TO) begin
            bad++;
            $display("FAIL wd_cycles: got err%b wait%0d want err1 wait%0d",
                     hit, cnt, TO);
        end
        total++;
        if (seen_valid || {AmValid_SO, AmReady_SO, ValidOut_SO} !== 3'b000) begin
            bad++;
            $display("FAIL wd_state: got seen%b hs%b want seen0 hs000",
                     seen_valid, {AmValid_SO, AmReady_SO, ValidOut_SO});
        end
        total++;
        if (exp_q.size() != 1) begin
            bad++;
            $display("FAIL wd_pending: got %0d want 1", exp_q.size());
        end
        exp_q.delete();
        am_respond = 1'b1;
        @(negedge Clk_CI);
        ReqValid_SI = 3'b001;
        #2;
        total++;
        if (ReqReady_SO !== 3'b001) begin
            bad++;
            $display("FAIL wd_next_grant: got %b want 001", ReqReady_SO);
        end
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        drain("wd");
        total++;
        if (TimeoutErr_SO !== 1'b1) begin
            bad++;
            $display("FAIL wd_sticky: got %b want 1", TimeoutErr_SO);
        end
    endtask

    task automatic test_reset_mid();
        bit waiting;
        am_respond = 1'b0;
        @(negedge Clk_CI);
        ReqHypervector_DI[HV +: HV] = 64'h5555_6666_7777_8888;
        ReqValid_SI = 3'b010;
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        waiting = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (AmReady_SO) begin
                waiting = 1'b1;
                break;
            end
            @(negedge Clk_CI);
        end
        total++;
        if (!waiting) begin
            bad++;
            $display("FAIL mid_wait: got 0 want 1");
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b1;
        am_clear = 1'b1;
        #2;
        total++;
        if ({AmValid_SO, AmReady_SO, ValidOut_SO} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_hs: got %b want 000",
                     {AmValid_SO, AmReady_SO, ValidOut_SO});
        end
        @(negedge Clk_CI);
        Reset_RI = 1'b0;
        exp_q.delete();
        grant_log.delete();
        #2;
        total++;
        if ({TimeoutErr_SO, AmReady_SO, ValidOut_SO, ReqIdOut_DO,
             LabelOut_A_DO, DistanceOut_A_DO} !== '0 ||
            AmHypervector_DO !== '0) begin
            bad++;
            $display("FAIL mid_after: got err%b rdy%b vo%b id%0d la%0d da%0d hv%h want all 0",
                     TimeoutErr_SO, AmReady_SO, ValidOut_SO, ReqIdOut_DO,
                     LabelOut_A_DO, DistanceOut_A_DO, AmHypervector_DO);
        end
        am_respond = 1'b1;
        @(negedge Clk_CI);
        ReqValid_SI = 3'b111;
        #2;
        total++;
        if (ReqReady_SO !== 3'b001) begin
            bad++;
            $display("FAIL mid_ptr: got %b want 001", ReqReady_SO);
        end
        @(negedge Clk_CI);
        ReqValid_SI = '0;
        drain("mid");
    endtask

    initial begin
        Reset_RI = 1'b1;
        ReqValid_SI = '0;
        ReqHypervector_DI = '0;
        ReadyIn_SI = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_watchdog();
        test_reset_mid();
        repeat (3) @(negedge Clk_CI);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_queue: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
